// File: rtl/irq_priority_controller.sv
// Memory-mapped fixed-priority interrupt controller: per-line enable/mode, SET, W1C pending, ISR nesting.
// Latency: line edge/level sampled at posedge n drives o_irq/o_vector in cycle n+1; reads are combinational.
// Backpressure: none; the bus completes every access in one cycle and i_ack is ignored while o_irq=0.
module irq_priority_controller #(
  parameter  int DATA_WIDTH = 32,
  parameter  int N_IRQ      = 8,
  localparam int ID_W       = $clog2(N_IRQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_IRQ-1:0]      i_irq,
  input  logic [2:0]            i_addr,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  input  logic                  i_ack,
  input  logic                  i_eoi,
  output logic                  o_irq,
  output logic [ID_W-1:0]       o_vector
);

  logic             gie;
  logic [N_IRQ-1:0] enable;
  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] isr;
  logic [N_IRQ-1:0] mode;     // 1 = rising edge, 0 = level
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] swset;    // software SET bits held on level lines until acked

  logic [N_IRQ-1:0] req;
  logic [ID_W-1:0]  top;
  logic [ID_W-1:0]  isr_top;
  logic             isr_any;

  logic             wr_ctrl, wr_enable, wr_pend, wr_set, wr_mode;
  logic [N_IRQ-1:0] w1c, sw_set, rise, ack_oh, eoi_oh;
  logic [N_IRQ-1:0] swset_nxt, pend_edge_nxt, pend_nxt, isr_nxt;
  logic             ack_fire;

  // Upper write-data bits have no storage behind them.
  logic unused_wdata;
  assign unused_wdata = ^i_wdata[DATA_WIDTH-1:N_IRQ];

  assign req = pend & enable;

  // Highest-index set bit of the request vector and of the in-service vector.
  always_comb begin
    top     = '0;
    isr_top = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (req[i]) top = ID_W'(i);
      if (isr[i]) isr_top = ID_W'(i);
    end
  end

  assign isr_any  = |isr;
  assign o_irq    = gie & (|req) & (~isr_any | (top > isr_top));
  assign o_vector = top;

  assign wr_ctrl   = i_we && (i_addr == 3'd0);
  assign wr_enable = i_we && (i_addr == 3'd2);
  assign wr_pend   = i_we && (i_addr == 3'd3);
  assign wr_set    = i_we && (i_addr == 3'd4);
  assign wr_mode   = i_we && (i_addr == 3'd5);

  assign ack_fire = i_ack & o_irq;
  assign w1c      = (wr_pend ? i_wdata[N_IRQ-1:0] : '0) & mode;
  assign sw_set   = wr_set ? i_wdata[N_IRQ-1:0] : '0;
  assign rise     = i_irq & ~irq_q & mode;
  assign ack_oh   = ack_fire ? (N_IRQ'(1) << top) : '0;
  assign eoi_oh   = (i_eoi && isr_any) ? (N_IRQ'(1) << isr_top) : '0;

  // Next pending/ISR state: sets are OR-ed in after clears so a new edge or SET wins.
  always_comb begin
    swset_nxt     = ((swset & ~ack_oh) | sw_set) & ~mode;
    pend_edge_nxt = (pend & ~w1c & ~ack_oh) | rise | sw_set;
    pend_nxt      = (mode & pend_edge_nxt) | (~mode & (swset_nxt | i_irq));
    isr_nxt       = (isr & ~eoi_oh) | ack_oh;
  end

  // Register file, interrupt state and line history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gie    <= 1'b0;
      enable <= '0;
      pend   <= '0;
      isr    <= '0;
      mode   <= '1;
      irq_q  <= '0;
      swset  <= '0;
    end else begin
      irq_q <= i_irq;
      pend  <= pend_nxt;
      swset <= swset_nxt;
      isr   <= isr_nxt;
      if (wr_ctrl)   gie    <= i_wdata[0];
      if (wr_enable) enable <= i_wdata[N_IRQ-1:0];
      if (wr_mode)   mode   <= i_wdata[N_IRQ-1:0];
    end
  end

  // Combinational read mux; unused bits and write-only/unmapped addresses read zero.
  always_comb begin
    o_rdata = '0;
    case (i_addr)
      3'd0: o_rdata[0] = gie;
      3'd1: begin
        o_rdata[N_IRQ-1:0]  = isr;
        o_rdata[15]         = o_irq;
        o_rdata[16 +: ID_W] = o_vector;
      end
      3'd2: o_rdata[N_IRQ-1:0] = enable;
      3'd3: o_rdata[N_IRQ-1:0] = pend;
      3'd5: o_rdata[N_IRQ-1:0] = mode;
      default: o_rdata = '0;
    endcase
  end

endmodule
